// File: rtl/mod_counter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mod_counter_pkg: shared defaults and direction encoding for mod_counter |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
package mod_counter_pkg;

  localparam int DEFAULT_WIDTH    = 5;
  localparam int DEFAULT_PRESCALE = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | step_prescaler: pulses step on every PRESCALE-th enabled clock          |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module step_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic w_unused;
      assign w_unused = ^{clock, reset, clear};
      assign step     = enable;
    end else begin : g_divide
      localparam int                  c_phase_w = $clog2(PRESCALE);
      localparam logic [c_phase_w-1:0] c_last   = c_phase_w'(PRESCALE - 1);

      logic [c_phase_w-1:0] r_phase;

      always_ff @(posedge clock) begin
        if (reset || clear) begin
          r_phase <= '0;
        end else if (enable) begin
          r_phase <= (r_phase == c_last) ? '0 : r_phase + 1'b1;
        end
      end

      assign step = enable && (r_phase == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mod_counter: prescaled up/down modulo-(MAX+1) counter with load and tc  |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int               PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic             w_step;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  // A load restarts the prescale phase so the next step is a full period away.
  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .step   (w_step)
  );

  assign w_load_clamped = (load_value > MAX) ? MAX : load_value;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      if (dir_e'(up) == DIR_UP) begin
        if (r_count == MAX) begin
          r_count <= '0;
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
          r_tc    <= 1'b0;
        end
      end else begin
        if (r_count == '0) begin
          r_count <= MAX;
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_count - 1'b1;
          r_tc    <= 1'b0;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mod_counter: two configurations against an arithmetic reference     |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module tb_mod_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       up;
  logic       load;
  logic [4:0] load_value;
  logic [4:0] count_a, count_b;
  logic       tc_a, tc_b;

  int errors = 0;
  int checks = 0;

  // index 0: MAX=31 PRESCALE=1, index 1: MAX=25 PRESCALE=3
  int c_max [2] = '{31, 25};
  int c_ps  [2] = '{1, 3};
  int m_cnt [2];
  int m_ph  [2];
  int m_tc  [2];

  always #5 clock = ~clock;

  mod_counter #(
    .WIDTH    (5),
    .MAX      (5'd31),
    .PRESCALE (1)
  ) dut_a (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count_a),
    .tc         (tc_a)
  );

  mod_counter #(
    .WIDTH    (5),
    .MAX      (5'd25),
    .PRESCALE (3)
  ) dut_b (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .count      (count_b),
    .tc         (tc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count lives in Z/(MAX+1); the prescaler is a phase that must reach PRESCALE-1.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_ph[i] = 0; m_tc[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_value) > c_max[i]) ? c_max[i] : int'(load_value);
        m_ph[i]  = 0;
        m_tc[i]  = 0;
      end else if (enable) begin
        if (m_ph[i] == c_ps[i] - 1) begin
          m_ph[i] = 0;
          if (up) begin
            m_tc[i]  = (m_cnt[i] == c_max[i]) ? 1 : 0;
            m_cnt[i] = (m_cnt[i] + 1) % (c_max[i] + 1);
          end else begin
            m_tc[i]  = (m_cnt[i] == 0) ? 1 : 0;
            m_cnt[i] = (m_cnt[i] + c_max[i]) % (c_max[i] + 1);
          end
        end else begin
          m_ph[i] = m_ph[i] + 1;
          m_tc[i] = 0;
        end
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic u, input logic l,
                      input logic [4:0] v);
    reset = r; enable = e; up = u; load = l; load_value = v;
    @(posedge clock);
    model_edge();
    #1;
    check("count_a", {27'd0, count_a}, m_cnt[0]);
    check("tc_a",    {31'd0, tc_a},    m_tc[0]);
    check("count_b", {27'd0, count_b}, m_cnt[1]);
    check("tc_b",    {31'd0, tc_b},    m_tc[1]);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = '0;

    tick(1'b1, 1'b1, 1'b1, 1'b1, 5'd9);
    check("rst_count_a", {27'd0, count_a}, 32'd0);
    check("rst_tc_b",    {31'd0, tc_b},    32'd0);

    // full up cycle through the wrap
    for (int i = 0; i < 32; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    check("wrap_count_a", {27'd0, count_a}, 32'd0);
    check("wrap_tc_a",    {31'd0, tc_a},    32'd1);

    // down from zero wraps to MAX
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    check("down_count_a", {27'd0, count_a}, 32'd29);

    // hold while disabled
    tick(1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    check("hold_resume_a", {27'd0, count_a}, 32'd8);

    // loads, including one above MAX for the second instance
    tick(1'b0, 1'b1, 1'b1, 1'b1, 5'd20);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 5'd30);
    check("clamp_b", {27'd0, count_b}, 32'd25);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    check("clamp_wrap_tc_b", {31'd0, tc_b}, 32'd1);

    // reset beats load and enable
    tick(1'b0, 1'b0, 1'b1, 1'b1, 5'd12);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 5'd5);
    check("rst_over_load_a", {27'd0, count_a}, 32'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);

    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0),
           5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
